// File: rtl/hazard_forward_unit.sv
// Forwarding, bypass and stall control beside the ID/EX pipeline registers, with a multi-cycle
// scoreboard. Define HAZ_PERF_CNT_EN to add the saturating StallCount performance counter.
module hazard_forward_unit #(
    parameter int AW         = 5,
    parameter int NUM_STAGES = 2,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32,
    localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [AW-1:0]            Rs_ID,
    input  logic [AW-1:0]            Rt_ID,
    input  logic [AW-1:0]            Rs_EX,
    input  logic [AW-1:0]            Rt_EX,
    input  logic [NUM_STAGES*AW-1:0] WriteRegAddress_P,
    input  logic [NUM_STAGES-1:0]    RegWrite_P,
    input  logic                     MemRead_EX,
    input  logic [AW-1:0]            WriteRegAddress_EX,
    input  logic                     MC_Op_ID,
    input  logic                     MC_Start,
    input  logic [AW-1:0]            MC_Dest,
    input  logic                     MC_Abort,
    output logic [SEL_W-1:0]         ReadData1Sel_EX,
    output logic [SEL_W-1:0]         ReadData2Sel_EX,
    output logic                     ReadData1Sel_ID,
    output logic                     ReadData2Sel_ID,
    output logic                     Stall_ID,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0]         StallCount,
`endif
    output logic                     MC_Busy,
    output logic                     MC_Done
);

    localparam int MCW = $clog2(MC_LATENCY);
    localparam int WB  = NUM_STAGES - 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [MCW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]   dest_q, dest_d;

    logic            load_use;
    logic            mc_dep;
    logic            mc_stall;

    // Stages are scanned oldest-first so the youngest matching producer overwrites the select.
    always_comb begin
        ReadData1Sel_EX = '0;
        ReadData2Sel_EX = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (RegWrite_P[k] && (Rs_EX != '0) && (WriteRegAddress_P[k*AW +: AW] == Rs_EX))
                ReadData1Sel_EX = SEL_W'(k + 1);
            if (RegWrite_P[k] && (Rt_EX != '0) && (WriteRegAddress_P[k*AW +: AW] == Rt_EX))
                ReadData2Sel_EX = SEL_W'(k + 1);
        end
    end

    always_comb begin
        ReadData1Sel_ID = RegWrite_P[WB] && (Rs_ID != '0) && (WriteRegAddress_P[WB*AW +: AW] == Rs_ID);
        ReadData2Sel_ID = RegWrite_P[WB] && (Rt_ID != '0) && (WriteRegAddress_P[WB*AW +: AW] == Rt_ID);
    end

    always_comb begin
        load_use = MemRead_EX && (WriteRegAddress_EX != '0) &&
                   ((Rs_ID == WriteRegAddress_EX) || (Rt_ID == WriteRegAddress_EX));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        MC_Done = 1'b0;
        if (MC_Abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (MC_Start) begin
                        state_d = S_BUSY;
                        cnt_d   = MCW'(MC_LATENCY - 1);
                        dest_d  = MC_Dest;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        MC_Done = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
        end
    end

    assign MC_Busy = (state_q == S_BUSY);

    // The start-cycle term lets a dependent instruction stall before the scoreboard has latched.
    always_comb begin
        mc_dep = MC_Op_ID ||
                 (MC_Busy && (dest_q != '0) && ((Rs_ID == dest_q) || (Rt_ID == dest_q))) ||
                 (MC_Start && (MC_Dest != '0) && ((Rs_ID == MC_Dest) || (Rt_ID == MC_Dest)));
        mc_stall = (MC_Busy || MC_Start) && mc_dep;
    end

    assign Stall_ID = load_use || mc_stall;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall_ID && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: vector table, multi-cycle corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_hazard_forward_unit;

    localparam int AW    = 5;
    localparam int NS    = 2;
    localparam int LAT   = 4;
    localparam int CW    = 3;
    localparam int SEL_W = $clog2(NS + 1);

    logic              Clk = 1'b0;
    logic              Rst;
    logic [AW-1:0]     Rs_ID, Rt_ID, Rs_EX, Rt_EX;
    logic [NS*AW-1:0]  WriteRegAddress_P;
    logic [NS-1:0]     RegWrite_P;
    logic              MemRead_EX;
    logic [AW-1:0]     WriteRegAddress_EX;
    logic              MC_Op_ID, MC_Start, MC_Abort;
    logic [AW-1:0]     MC_Dest;
    logic [SEL_W-1:0]  ReadData1Sel_EX, ReadData2Sel_EX;
    logic              ReadData1Sel_ID, ReadData2Sel_ID;
    logic              Stall_ID, MC_Busy, MC_Done;
`ifdef HAZ_PERF_CNT_EN
    logic [CW-1:0]     StallCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hazard_forward_unit #(
        .AW(AW), .NUM_STAGES(NS), .MC_LATENCY(LAT), .CNT_W(CW)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Rs_ID(Rs_ID),
        .Rt_ID(Rt_ID),
        .Rs_EX(Rs_EX),
        .Rt_EX(Rt_EX),
        .WriteRegAddress_P(WriteRegAddress_P),
        .RegWrite_P(RegWrite_P),
        .MemRead_EX(MemRead_EX),
        .WriteRegAddress_EX(WriteRegAddress_EX),
        .MC_Op_ID(MC_Op_ID),
        .MC_Start(MC_Start),
        .MC_Dest(MC_Dest),
        .MC_Abort(MC_Abort),
        .ReadData1Sel_EX(ReadData1Sel_EX),
        .ReadData2Sel_EX(ReadData2Sel_EX),
        .ReadData1Sel_ID(ReadData1Sel_ID),
        .ReadData2Sel_ID(ReadData2Sel_ID),
        .Stall_ID(Stall_ID),
`ifdef HAZ_PERF_CNT_EN
        .StallCount(StallCount),
`endif
        .MC_Busy(MC_Busy),
        .MC_Done(MC_Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [AW-1:0]    rs_ex, rt_ex, rs_id, rt_id, wr_ex;
        logic [AW-1:0]    wb_addr, mem_addr;
        logic [NS-1:0]    rw;
        logic             mem_rd;
        logic [SEL_W-1:0] e_sel1, e_sel2;
        logic             e_id1, e_id2, e_stall;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs_ID = '0; Rt_ID = '0; Rs_EX = '0; Rt_EX = '0;
        WriteRegAddress_P = '0; RegWrite_P = '0;
        MemRead_EX = 1'b0; WriteRegAddress_EX = '0;
        MC_Op_ID = 1'b0; MC_Start = 1'b0; MC_Dest = '0; MC_Abort = 1'b0;
    endtask

    task automatic add_vec(input int rs_ex, rt_ex, wb, mem, rw, mrd, wrex, rs_id, rt_id,
                           input int s1, s2, i1, i2, st);
        vec_t v;
        v.rs_ex = AW'(rs_ex); v.rt_ex = AW'(rt_ex); v.wb_addr = AW'(wb); v.mem_addr = AW'(mem);
        v.rw = NS'(rw); v.mem_rd = mrd[0]; v.wr_ex = AW'(wrex);
        v.rs_id = AW'(rs_id); v.rt_id = AW'(rt_id);
        v.e_sel1 = SEL_W'(s1); v.e_sel2 = SEL_W'(s2);
        v.e_id1 = i1[0]; v.e_id2 = i2[0]; v.e_stall = st[0];
        vecs.push_back(v);
    endtask

    // Reference model state: cycles left until the pending result is written (0 = none).
    int            m_left;
    logic [AW-1:0] m_dest;
    int            m_cnt;

    function automatic int first_src(input logic [AW-1:0] r);
        if (r == 0) return 0;
        for (int k = 0; k < NS; k++)
            if (RegWrite_P[k] && WriteRegAddress_P[k*AW +: AW] == r) return k + 1;
        return 0;
    endfunction

    function automatic bit reads(input logic [AW-1:0] r);
        return (r != 0) && (Rs_ID == r || Rt_ID == r);
    endfunction

    task automatic model_check_and_step();
        bit busy, done, lu, st;
        busy = (m_left > 0);
        done = (m_left == 1) && !MC_Abort;
        lu = MemRead_EX && reads(WriteRegAddress_EX);
        st = lu || ((busy || MC_Start) &&
                    (MC_Op_ID || (busy && reads(m_dest)) || (MC_Start && reads(MC_Dest))));
        chk("rnd_sel1", ReadData1Sel_EX, first_src(Rs_EX));
        chk("rnd_sel2", ReadData2Sel_EX, first_src(Rt_EX));
        chk("rnd_id1", ReadData1Sel_ID, RegWrite_P[NS-1] && Rs_ID != 0 && WriteRegAddress_P[(NS-1)*AW +: AW] == Rs_ID);
        chk("rnd_id2", ReadData2Sel_ID, RegWrite_P[NS-1] && Rt_ID != 0 && WriteRegAddress_P[(NS-1)*AW +: AW] == Rt_ID);
        chk("rnd_busy", MC_Busy, busy);
        chk("rnd_done", MC_Done, done);
        chk("rnd_stall", Stall_ID, st);
`ifdef HAZ_PERF_CNT_EN
        chk("rnd_count", StallCount, m_cnt);
`endif
        if (st && m_cnt < (1 << CW) - 1) m_cnt++;
        if (MC_Abort) m_left = 0;
        else if (busy) m_left--;
        else if (MC_Start) begin
            m_left = LAT;
            m_dest = MC_Dest;
        end
        tick();
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        #3;
        Rst = 1'b0;
        tick();
        m_left = 0; m_dest = '0; m_cnt = 0;
    endtask

    initial begin
        Rst = 1'b1;
        clear_inputs();
        #2;
        chk("rst_busy", MC_Busy, 0);
        chk("rst_done", MC_Done, 0);
        chk("rst_stall", Stall_ID, 0);
`ifdef HAZ_PERF_CNT_EN
        chk("rst_count", StallCount, 0);
`endif
        #10;
        Rst = 1'b0;
        tick();

        //       rs_ex rt_ex wb mem rw mrd wrex rs_id rt_id  s1 s2 i1 i2 st
        add_vec(3, 0, 3, 3, 3, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        add_vec(3, 0, 3, 3, 2, 0, 0, 0, 0,   2, 0, 0, 0, 0);
        add_vec(0, 0, 3, 3, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add_vec(1, 2, 4, 6, 3, 1, 5, 0, 5,   0, 0, 0, 0, 1);
        add_vec(1, 2, 4, 6, 3, 1, 0, 0, 5,   0, 0, 0, 0, 0);
        add_vec(9, 4, 4, 9, 3, 0, 0, 4, 9,   1, 2, 1, 0, 0);
        add_vec(9, 4, 4, 9, 1, 0, 0, 4, 9,   1, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add_vec(6, 6, 6, 2, 3, 1, 6, 6, 0,   2, 2, 1, 0, 1);
        add_vec(6, 6, 6, 2, 3, 0, 6, 6, 0,   2, 2, 1, 0, 0);

        foreach (vecs[i]) begin
            clear_inputs();
            Rs_EX = vecs[i].rs_ex; Rt_EX = vecs[i].rt_ex;
            WriteRegAddress_P = {vecs[i].wb_addr, vecs[i].mem_addr};
            RegWrite_P = vecs[i].rw; MemRead_EX = vecs[i].mem_rd;
            WriteRegAddress_EX = vecs[i].wr_ex;
            Rs_ID = vecs[i].rs_id; Rt_ID = vecs[i].rt_id;
            #4;
            chk($sformatf("vec%0d_sel1", i), ReadData1Sel_EX, vecs[i].e_sel1);
            chk($sformatf("vec%0d_sel2", i), ReadData2Sel_EX, vecs[i].e_sel2);
            chk($sformatf("vec%0d_id1", i), ReadData1Sel_ID, vecs[i].e_id1);
            chk($sformatf("vec%0d_id2", i), ReadData2Sel_ID, vecs[i].e_id2);
            chk($sformatf("vec%0d_stall", i), Stall_ID, vecs[i].e_stall);
            tick();
        end

        // Full multi-cycle op with dependent reader held in ID
        clear_inputs();
        Rs_ID = 5'd7; MC_Start = 1'b1; MC_Dest = 5'd7;
        #4;
        chk("mcA_T_stall", Stall_ID, 1);
        chk("mcA_T_busy", MC_Busy, 0);
        tick();
        MC_Start = 1'b0; MC_Dest = '0;
        for (int i = 1; i <= LAT + 1; i++) begin
            #4;
            chk($sformatf("mcA_T%0d_stall", i), Stall_ID, i <= LAT);
            chk($sformatf("mcA_T%0d_busy", i), MC_Busy, i <= LAT);
            chk($sformatf("mcA_T%0d_done", i), MC_Done, i == LAT);
            tick();
        end

        // Abort at T+2
        MC_Start = 1'b1; MC_Dest = 5'd7;
        tick();
        MC_Start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            MC_Abort = (i == 2);
            #4;
            chk($sformatf("mcB_T%0d_busy", i), MC_Busy, i <= 2);
            chk($sformatf("mcB_T%0d_done", i), MC_Done, 0);
            chk($sformatf("mcB_T%0d_stall", i), Stall_ID, i <= 2);
            tick();
        end
        MC_Abort = 1'b0;

        // Start while busy is ignored; original op completes on schedule
        Rs_ID = '0;
        MC_Start = 1'b1; MC_Dest = 5'd7;
        tick();
        MC_Start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            MC_Start = (i == 2);
            MC_Dest = (i == 2) ? 5'd8 : 5'd0;
            MC_Op_ID = (i == 3);
            #4;
            chk($sformatf("mcC_T%0d_busy", i), MC_Busy, i <= LAT);
            chk($sformatf("mcC_T%0d_done", i), MC_Done, i == LAT);
            chk($sformatf("mcC_T%0d_stall", i), Stall_ID, i == 3);
            tick();
        end
        clear_inputs();

        // Async reset mid-busy
        Rs_ID = 5'd7; MC_Start = 1'b1; MC_Dest = 5'd7;
        tick();
        MC_Start = 1'b0;
        tick();
        #2;
        Rst = 1'b1;
        #1;
        chk("mcD_rst_busy", MC_Busy, 0);
        chk("mcD_rst_stall", Stall_ID, 0);
        Rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            #4;
            chk($sformatf("mcD_post%0d_done", i), MC_Done, 0);
            chk($sformatf("mcD_post%0d_busy", i), MC_Busy, 0);
            tick();
        end
        clear_inputs();

`ifdef HAZ_PERF_CNT_EN
        do_reset();
        MemRead_EX = 1'b1; WriteRegAddress_EX = 5'd5; Rt_ID = 5'd5;
        for (int i = 0; i < 10; i++) tick();
        clear_inputs();
        #4;
        chk("cnt_sat", StallCount, 7);
        Rst = 1'b1;
        #1;
        chk("cnt_rst", StallCount, 0);
        Rst = 1'b0;
        tick();
`endif

        do_reset();
        for (int n = 0; n < 2000; n++) begin
            Rs_ID = AW'($urandom_range(0, 3)); Rt_ID = AW'($urandom_range(0, 3));
            Rs_EX = AW'($urandom_range(0, 3)); Rt_EX = AW'($urandom_range(0, 3));
            WriteRegAddress_P = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
            RegWrite_P = NS'($urandom);
            MemRead_EX = ($urandom_range(0, 3) == 0);
            WriteRegAddress_EX = AW'($urandom_range(0, 3));
            MC_Op_ID = ($urandom_range(0, 7) == 0);
            MC_Start = ($urandom_range(0, 5) == 0);
            MC_Dest = AW'($urandom_range(0, 3));
            MC_Abort = ($urandom_range(0, 19) == 0);
            #4;
            model_check_and_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
